// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory command port
// and the contention counter. slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              I_Req;
  logic [ADDR_W-1:0] I_Addr;
  logic              I_Gnt;
  logic              I_Valid;
  logic [DATA_W-1:0] I_RData;

  logic              D_Req;
  logic              D_We;
  logic [ADDR_W-1:0] D_Addr;
  logic [DATA_W-1:0] D_WData;
  logic              D_Gnt;
  logic              D_Valid;
  logic [DATA_W-1:0] D_RData;

  logic [ADDR_W-1:0] M_Address;
  logic [DATA_W-1:0] M_WriteData;
  logic              M_MemRead;
  logic              M_MemWrite;
  logic [DATA_W-1:0] M_ReadData;

  logic [CNT_W-1:0]  ContentionCnt;

  modport slave (
    input  I_Req, I_Addr, D_Req, D_We, D_Addr, D_WData, M_ReadData,
    output I_Gnt, I_Valid, I_RData, D_Gnt, D_Valid, D_RData,
           M_Address, M_WriteData, M_MemRead, M_MemWrite, ContentionCnt
  );

  modport master (
    output I_Req, I_Addr, D_Req, D_We, D_Addr, D_WData, M_ReadData,
    input  I_Gnt, I_Valid, I_RData, D_Gnt, D_Valid, D_RData,
           M_Address, M_WriteData, M_MemRead, M_MemWrite, ContentionCnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory, one access per 2 cycles.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate winners on contention (else D has fixed priority).
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1: data port owns the access
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                m_rd_q, m_rd_d;
  logic                m_wr_q, m_wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                last_d_q, last_d_d;
`endif

  logic can_grant, d_win, i_gnt, d_gnt, i_valid, d_valid, contend;

  // Arbitration, next-state and command capture
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_rd_d    = 1'b0;
    m_wr_d    = 1'b0;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_d  = last_d_q;
    d_win     = bus.D_Req && (!bus.I_Req || !last_d_q);
`else
    d_win     = bus.D_Req;
`endif

    can_grant = Rst_n && (state_q != ISSUE);
    d_gnt     = can_grant && d_win;
    i_gnt     = can_grant && bus.I_Req && !d_win;

    case (state_q)
      IDLE:    if (i_gnt || d_gnt) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP: begin
        // Reset in the response cycle drops the pulse outright
        i_valid = Rst_n && !owner_q;
        d_valid = Rst_n && owner_q;
        if (!owner_q)         i_rdata_d = bus.M_ReadData;
        if (owner_q && !we_q) d_rdata_d = bus.M_ReadData;
        state_d = (i_gnt || d_gnt) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (d_gnt) begin
      owner_d   = 1'b1;
      we_d      = bus.D_We;
      m_addr_d  = bus.D_Addr & ~ADDR_W'(3);
      m_wdata_d = bus.D_WData;
      m_rd_d    = !bus.D_We;
      m_wr_d    = bus.D_We;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_d  = 1'b1;
`endif
    end else if (i_gnt) begin
      owner_d   = 1'b0;
      we_d      = 1'b0;
      m_addr_d  = bus.I_Addr & ~ADDR_W'(3);
      m_rd_d    = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_d  = 1'b0;
`endif
    end

    contend = (bus.I_Req && !i_gnt) || (bus.D_Req && !d_gnt);
    if (contend && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  // Read data is passed straight through during RESP, then held
  assign bus.I_Gnt         = i_gnt;
  assign bus.D_Gnt         = d_gnt;
  assign bus.I_Valid       = i_valid;
  assign bus.D_Valid       = d_valid;
  assign bus.I_RData       = (state_q == RESP && !owner_q) ? bus.M_ReadData : i_rdata_q;
  assign bus.D_RData       = (state_q == RESP && owner_q && !we_q) ? bus.M_ReadData : d_rdata_q;
  assign bus.M_Address     = m_addr_q;
  assign bus.M_WriteData   = m_wdata_q;
  assign bus.M_MemRead     = m_rd_q;
  assign bus.M_MemWrite    = m_wr_q;
  assign bus.ContentionCnt = cnt_q;

endmodule
